// File: rtl/lane_hit_scorer.sv
// Multi-lane hit judge: grades button edges against one-hot note positions,
// charges pass-misses in harder mode, and keeps a saturating score and combo.
module lane_hit_scorer #(
    parameter int unsigned LANES       = 4,
    parameter int unsigned COLS        = 5,
    parameter int unsigned SCORE_W     = 10,
    parameter int unsigned COMBO_W     = 4,
    parameter int unsigned PERFECT_PTS = 2,
    parameter int unsigned GOOD_PTS    = 1,
    parameter int unsigned MISS_PEN    = 2,
    parameter int unsigned BONUS_AT    = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [LANES-1:0]         press_i,
    input  logic [LANES*COLS-1:0]    column_i,
    input  logic                     harder_i,
    input  logic                     stop_i,
    output logic [2*LANES-1:0]       judge_o,
    output logic [SCORE_W-1:0]       score_o,
    output logic [COMBO_W-1:0]       combo_o
);

    localparam int unsigned CT = COLS / 2;
    localparam int unsigned SW = SCORE_W + 4;
    localparam int unsigned CW = COMBO_W + 4;

    localparam logic [SW-1:0]      PerfectPts = SW'(PERFECT_PTS);
    localparam logic [SW-1:0]      GoodPts    = SW'(GOOD_PTS);
    localparam logic [SW-1:0]      MissPen    = SW'(MISS_PEN);
    localparam logic [SW-1:0]      ScoreMax   = SW'({SCORE_W{1'b1}});
    localparam logic [CW-1:0]      ComboMax   = CW'({COMBO_W{1'b1}});
    localparam logic [COMBO_W-1:0] BonusAt    = COMBO_W'(BONUS_AT);

    typedef enum logic [1:0] {
        GrNone    = 2'b00,
        GrGood    = 2'b01,
        GrPerfect = 2'b10,
        GrMiss    = 2'b11
    } grade_e;

    logic [LANES-1:0]      press_q, hit_done_q, hit_done_d, edge_w;
    logic [LANES*COLS-1:0] col_q;
    logic [2*LANES-1:0]    judge_q, judge_d;
    logic [SCORE_W-1:0]    score_q, score_d;
    logic [COMBO_W-1:0]    combo_q, combo_d;
    logic [SW-1:0]         gain, loss, bonus, sum;
    logic [CW-1:0]         n_hits, combo_sum;
    logic                  any_miss;
    logic [COLS-1:0]       lane_col, prev_col;
    grade_e                grade;

    always_comb begin
        // stop discards edges outright; press_q still follows press below
        edge_w     = press_i & ~press_q & {LANES{~stop_i}};
        hit_done_d = hit_done_q;
        judge_d    = '0;
        gain       = '0;
        loss       = '0;
        n_hits     = '0;
        any_miss   = 1'b0;
        lane_col   = '0;
        prev_col   = '0;
        grade      = GrNone;
        bonus      = (combo_q >= BonusAt) ? SW'(1) : '0;

        for (int i = 0; i < LANES; i++) begin
            lane_col = column_i[i*COLS +: COLS];
            prev_col = col_q[i*COLS +: COLS];
            grade    = GrNone;
            if (edge_w[i]) begin
                if (hit_done_q[i]) begin
                    grade = GrMiss;
                end else if (lane_col[CT]) begin
                    grade = GrPerfect;
                end else if (lane_col[CT-1] || lane_col[CT+1]) begin
                    grade = GrGood;
                end else begin
                    grade = GrMiss;
                end
            end else if (!stop_i && harder_i && !hit_done_q[i] &&
                         prev_col != '0 && lane_col == '0) begin
                grade = GrMiss;
            end

            unique case (grade)
                GrPerfect: begin
                    gain   = gain + PerfectPts + bonus;
                    n_hits = n_hits + CW'(1);
                end
                GrGood: begin
                    gain   = gain + GoodPts + bonus;
                    n_hits = n_hits + CW'(1);
                end
                GrMiss: begin
                    loss     = loss + MissPen;
                    any_miss = 1'b1;
                end
                default: ;
            endcase

            judge_d[2*i +: 2] = grade;
            if (lane_col == '0) begin
                hit_done_d[i] = 1'b0;
            end else if (grade == GrPerfect || grade == GrGood) begin
                hit_done_d[i] = 1'b1;
            end
        end

        // Wrapped-negative shows up as the top bit of the widened sum
        sum = SW'(score_q) + gain - loss;
        if (sum[SW-1]) begin
            score_d = '0;
        end else if (sum > ScoreMax) begin
            score_d = '1;
        end else begin
            score_d = sum[SCORE_W-1:0];
        end

        combo_sum = CW'(combo_q) + n_hits;
        if (any_miss) begin
            combo_d = '0;
        end else if (combo_sum > ComboMax) begin
            combo_d = '1;
        end else begin
            combo_d = combo_sum[COMBO_W-1:0];
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            press_q    <= '0;
            col_q      <= '0;
            hit_done_q <= '0;
            judge_q    <= '0;
            score_q    <= '0;
            combo_q    <= '0;
        end else begin
            press_q    <= press_i;
            col_q      <= column_i;
            hit_done_q <= hit_done_d;
            judge_q    <= judge_d;
            score_q    <= score_d;
            combo_q    <= combo_d;
        end
    end

    assign judge_o = judge_q;
    assign score_o = score_q;
    assign combo_o = combo_q;

endmodule

// File: tb/tb_lane_hit_scorer.sv
// Bench for lane_hit_scorer: scenario table, saturation/reset sequence, and
// randomized play checked against a distance-based scoring model.
module tb_lane_hit_scorer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  press;
    logic [19:0] column;
    logic        harder, stop;
    logic [7:0]  judge;
    logic [9:0]  score;
    logic [3:0]  combo;

    lane_hit_scorer dut (
        .Clock    (clk),
        .Reset    (rst),
        .press_i  (press),
        .column_i (column),
        .harder_i (harder),
        .stop_i   (stop),
        .judge_o  (judge),
        .score_o  (score),
        .combo_o  (combo)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state
    int   m_score, m_combo;
    int   m_colq [4];
    bit   m_pq   [4];
    bit   m_done [4];
    logic [7:0] e_judge;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // 0 none, 1 good, 2 perfect, 3 miss; graded by distance from the target column
    function automatic int grade_of(input int col, input bit done);
        int pos, d;
        if (done) return 3;
        pos = -1;
        for (int b = 0; b < 5; b++) if (col[b]) pos = b;
        if (pos < 0) return 3;
        d = (pos > 2) ? pos - 2 : 2 - pos;
        if (d == 0) return 2;
        if (d == 1) return 1;
        return 3;
    endfunction

    task automatic model_step(input logic [3:0] p, input logic [19:0] c, input logic h,
                              input logic s, input logic r);
        int gain, hits, misses, g, lc;
        bit bonus;
        e_judge = '0;
        if (r) begin
            m_score = 0;
            m_combo = 0;
            for (int i = 0; i < 4; i++) begin
                m_colq[i] = 0; m_pq[i] = 0; m_done[i] = 0;
            end
            return;
        end
        gain = 0; hits = 0; misses = 0;
        bonus = (m_combo >= 4);
        for (int i = 0; i < 4; i++) begin
            lc = int'(c >> (5 * i)) & 31;
            g = 0;
            if (p[i] && !m_pq[i] && !s) g = grade_of(lc, m_done[i]);
            else if (!s && h && m_colq[i] != 0 && lc == 0 && !m_done[i]) g = 3;
            if (g == 1 || g == 2) begin
                hits++;
                gain += ((g == 2) ? 2 : 1) + (bonus ? 1 : 0);
            end
            if (g == 3) misses++;
            e_judge[2*i +: 2] = 2'(g);
            if (lc == 0) m_done[i] = 0;
            else if (g == 1 || g == 2) m_done[i] = 1;
            m_colq[i] = lc;
            m_pq[i]   = p[i];
        end
        m_score = m_score + gain - 2 * misses;
        if (m_score < 0) m_score = 0;
        if (m_score > 1023) m_score = 1023;
        m_combo = (misses > 0) ? 0 : ((m_combo + hits > 15) ? 15 : m_combo + hits);
    endtask

    // One clock: drive on the falling edge, check the model #1 after the rising edge
    task automatic cyc(input logic [3:0] p, input logic [19:0] c, input logic h,
                       input logic s, input logic r);
        @(negedge clk);
        press = p; column = c; harder = h; stop = s; rst = r;
        model_step(p, c, h, s, r);
        @(posedge clk);
        #1;
        chk("model_judge", int'(judge), int'(e_judge));
        chk("model_score", int'(score), m_score);
        chk("model_combo", int'(combo), m_combo);
    endtask

    function automatic logic [19:0] mk(input logic [4:0] c0, input logic [4:0] c1,
                                       input logic [4:0] c2, input logic [4:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    typedef struct {
        logic [3:0]  p;
        logic [19:0] c;
        logic        h;
        logic        s;
        logic [7:0]  ej;
        int          es;
        int          ec;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] p, input logic [19:0] c, input logic h,
                       input logic s, input logic [7:0] ej, input int es, input int ec);
        vec_t v;
        v.p = p; v.c = c; v.h = h; v.s = s; v.ej = ej; v.es = es; v.ec = ec;
        tbl.push_back(v);
    endtask

    logic [4:0] rc [4];
    logic [3:0] rp;

    initial begin
        press = '0; column = '0; harder = 1'b0; stop = 1'b0; rst = 1'b1;
        cyc(4'h0, '0, 1'b0, 1'b0, 1'b1);
        cyc(4'h0, '0, 1'b0, 1'b0, 1'b1);
        chk("reset_judge", int'(judge), 0);
        chk("reset_score", int'(score), 0);
        chk("reset_combo", int'(combo), 0);

        // perfect on lane0, release
        add(4'b0001, mk(5'b00100, 0, 0, 0), 0, 0, 8'b00000010, 2, 1);
        add(4'b0001, mk(5'b00100, 0, 0, 0), 0, 0, 8'b00000000, 2, 1);
        add(4'b0000, mk(0, 0, 0, 0),        0, 0, 8'b00000000, 2, 1);
        // good on lane1, then double tap on the same note
        add(4'b0010, mk(0, 5'b01000, 0, 0), 0, 0, 8'b00000100, 3, 2);
        add(4'b0000, mk(0, 5'b01000, 0, 0), 0, 0, 8'b00000000, 3, 2);
        add(4'b0010, mk(0, 5'b01000, 0, 0), 0, 0, 8'b00001100, 1, 0);
        add(4'b0000, mk(0, 0, 0, 0),        0, 0, 8'b00000000, 1, 0);
        // unhit note leaves lane2 in harder mode, score clamps at 0
        add(4'b0000, mk(0, 0, 5'b00001, 0), 1, 0, 8'b00000000, 1, 0);
        add(4'b0000, mk(0, 0, 0, 0),        1, 0, 8'b00110000, 0, 0);
        // build combo to 4
        add(4'b0001, mk(5'b00100, 0, 0, 0), 0, 0, 8'b00000010, 2, 1);
        add(4'b0000, mk(0, 0, 0, 0),        0, 0, 8'b00000000, 2, 1);
        add(4'b0001, mk(5'b00100, 0, 0, 0), 0, 0, 8'b00000010, 4, 2);
        add(4'b0000, mk(0, 0, 0, 0),        0, 0, 8'b00000000, 4, 2);
        add(4'b0001, mk(5'b00100, 0, 0, 0), 0, 0, 8'b00000010, 6, 3);
        add(4'b0000, mk(0, 0, 0, 0),        0, 0, 8'b00000000, 6, 3);
        add(4'b0001, mk(5'b00100, 0, 0, 0), 0, 0, 8'b00000010, 8, 4);
        add(4'b0000, mk(0, 0, 0, 0),        0, 0, 8'b00000000, 8, 4);
        // two bonus perfects, then two bonus perfects plus a lane1 miss
        add(4'b1001, mk(5'b00100, 0, 0, 5'b00100), 0, 0, 8'b10000010, 14, 6);
        add(4'b0000, mk(0, 0, 0, 0),               0, 0, 8'b00000000, 14, 6);
        add(4'b1011, mk(5'b00100, 0, 0, 5'b00100), 0, 0, 8'b10001110, 18, 0);
        add(4'b0000, mk(0, 0, 0, 0),               0, 0, 8'b00000000, 18, 0);
        // edge under stop is dropped, held button across release does not fire
        add(4'b0001, mk(5'b00100, 0, 0, 0), 0, 1, 8'b00000000, 18, 0);
        add(4'b0001, mk(5'b00100, 0, 0, 0), 0, 0, 8'b00000000, 18, 0);
        add(4'b0000, mk(0, 0, 0, 0),        0, 0, 8'b00000000, 18, 0);
        // no pass-miss while stopped
        add(4'b0000, mk(0, 0, 5'b00100, 0), 1, 0, 8'b00000000, 18, 0);
        add(4'b0000, mk(0, 0, 0, 0),        1, 1, 8'b00000000, 18, 0);
        add(4'b0000, mk(0, 0, 0, 0),        1, 0, 8'b00000000, 18, 0);
        // edge coinciding with a pass-miss is graded once
        add(4'b0000, mk(0, 0, 0, 5'b10000), 1, 0, 8'b00000000, 18, 0);
        add(4'b1000, mk(0, 0, 0, 0),        1, 0, 8'b11000000, 16, 0);
        // hit note leaving in harder mode is not a miss
        add(4'b0001, mk(5'b00010, 0, 0, 0), 1, 0, 8'b00000001, 17, 1);
        add(4'b0000, mk(0, 0, 0, 0),        1, 0, 8'b00000000, 17, 1);

        foreach (tbl[k]) begin
            cyc(tbl[k].p, tbl[k].c, tbl[k].h, tbl[k].s, 1'b0);
            chk($sformatf("tbl%0d_judge", k), int'(judge), int'(tbl[k].ej));
            chk($sformatf("tbl%0d_score", k), int'(score), tbl[k].es);
            chk($sformatf("tbl%0d_combo", k), int'(combo), tbl[k].ec);
        end

        // pump all four lanes until score and combo saturate
        for (int k = 0; k < 120; k++) begin
            cyc(4'hf, mk(5'b00100, 5'b00100, 5'b00100, 5'b00100), 1'b0, 1'b0, 1'b0);
            cyc(4'h0, '0, 1'b0, 1'b0, 1'b0);
        end
        chk("sat_score", int'(score), 1023);
        chk("sat_combo", int'(combo), 15);

        cyc(4'h0, '0, 1'b0, 1'b0, 1'b1);
        chk("rst_mid_judge", int'(judge), 0);
        chk("rst_mid_score", int'(score), 0);
        chk("rst_mid_combo", int'(combo), 0);

        // randomized play
        for (int i = 0; i < 4; i++) rc[i] = '0;
        rp = '0;
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 4) == 0) rc[i] = '0;
                    else rc[i] = 5'(1 << $urandom_range(0, 4));
                end
                if ($urandom_range(0, 2) == 0) rp[i] = ~rp[i];
            end
            cyc(rp, mk(rc[0], rc[1], rc[2], rc[3]),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 99) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
